// File: rtl/ddr3_maint_scheduler_pkg.sv
// Shared widths, command encodings and bundle type for the DDR3 maintenance
// scheduler and its neighbours in the command path.
package ddr3_maint_scheduler_pkg;

    localparam int BANK_WIDTH       = 3;
    localparam int ROW_WIDTH        = 14;
    localparam int COL_WIDTH        = 10;
    localparam int MAX_POSTPONE_DEF = 8;

    localparam logic [3:0] NOP_ALL  = 4'hF;
    localparam logic [3:0] SLOT0    = 4'b0001;
    localparam logic [3:0] NOP_REST = 4'b1110;

    typedef struct packed {
        logic [3:0]              wr;
        logic [3:0]              rd;
        logic [3:0]              pre;
        logic [3:0]              act;
        logic [3:0]              refr;
        logic [3:0]              zq;
        logic [3:0]              nop;
        logic [3:0]              pall;
        logic [4*BANK_WIDTH-1:0] bank;
        logic [4*ROW_WIDTH-1:0]  row;
        logic [4*COL_WIDTH-1:0]  col;
    } ddr_bundle_t;

    function automatic ddr_bundle_t nop_bundle();
        ddr_bundle_t b;
        b     = '0;
        b.nop = NOP_ALL;
        return b;
    endfunction

endpackage

// File: rtl/ddr3_refi_timer.sv
// Free-running refresh-interval timer; one-cycle tick on each wrap.
module ddr3_refi_timer #(
    parameter int TREFI_CYC = 1950
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int CW = (TREFI_CYC > 1) ? $clog2(TREFI_CYC) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          wrap;

    assign wrap = (cnt_q == CW'(TREFI_CYC - 1));
    assign tick = en & wrap;

    always_comb begin
        cnt_d = cnt_q;
        if (!en) begin
            cnt_d = '0;
        end else if (wrap) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ddr3_maint_scheduler.sv
// Forwards 4-slot command bundles to ddr3_adapter and interleaves
// PRE-ALL/REF/ZQCS maintenance sequences, tracking postponed refresh debt.
module ddr3_maint_scheduler
    import ddr3_maint_scheduler_pkg::*;
#(
    parameter int TREFI_CYC    = 1950,
    parameter int TRP_CYC      = 4,
    parameter int TRFC_CYC     = 66,
    parameter int TZQCS_CYC    = 16,
    parameter int ZQ_INTERVAL  = 128,
    parameter int MAX_POSTPONE = MAX_POSTPONE_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    init_calib_complete,
    input  logic                    maint_en,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [3:0]              req_write,
    input  logic [3:0]              req_read,
    input  logic [3:0]              req_pre,
    input  logic [3:0]              req_act,
    input  logic [3:0]              req_ref,
    input  logic [3:0]              req_zq,
    input  logic [3:0]              req_nop,
    input  logic [3:0]              req_pall,
    input  logic [4*BANK_WIDTH-1:0] req_bank,
    input  logic [4*ROW_WIDTH-1:0]  req_row,
    input  logic [4*COL_WIDTH-1:0]  req_col,
    output logic [3:0]              ddr_write,
    output logic [3:0]              ddr_read,
    output logic [3:0]              ddr_pre,
    output logic [3:0]              ddr_act,
    output logic [3:0]              ddr_ref,
    output logic [3:0]              ddr_zq,
    output logic [3:0]              ddr_nop,
    output logic [3:0]              ddr_pall,
    output logic [4*BANK_WIDTH-1:0] ddr_bank,
    output logic [4*ROW_WIDTH-1:0]  ddr_row,
    output logic [4*COL_WIDTH-1:0]  ddr_col,
    output logic                    maint_busy,
    output logic [3:0]              ref_debt,
    output logic                    ref_overflow
);

    typedef enum logic [2:0] {
        S_PASS,
        S_PREA,
        S_WAIT_RP,
        S_REF,
        S_WAIT_RFC,
        S_ZQ,
        S_WAIT_ZQ
    } state_e;

    localparam int WMAX0 = (TRP_CYC > TRFC_CYC) ? TRP_CYC : TRFC_CYC;
    localparam int WMAX  = (WMAX0 > TZQCS_CYC) ? WMAX0 : TZQCS_CYC;
    localparam int WCW   = $clog2(WMAX + 1);
    localparam int ZCW   = (ZQ_INTERVAL > 1) ? $clog2(ZQ_INTERVAL) : 1;

    localparam logic [3:0] MAXP = 4'(MAX_POSTPONE);

    state_e           state_q, state_d;
    logic [WCW-1:0]   wcnt_q, wcnt_d;
    logic [ZCW-1:0]   zq_cnt_q, zq_cnt_d;
    logic [3:0]       debt_q, debt_d;
    logic             ovf_q, ovf_d;
    ddr_bundle_t      out_q, out_d;
    ddr_bundle_t      req_b;
    logic             tick;
    logic             ref_issue;
    logic             start_maint;
    logic             accept;
    logic             wdone;

    ddr3_refi_timer #(
        .TREFI_CYC(TREFI_CYC)
    ) u_refi (
        .clk (clk),
        .rst (rst),
        .en  (init_calib_complete),
        .tick(tick)
    );

    assign req_b = '{wr:   req_write, rd:   req_read,
                     pre:  req_pre,   act:  req_act,
                     refr: req_ref,   zq:   req_zq,
                     nop:  req_nop,   pall: req_pall,
                     bank: req_bank,  row:  req_row,
                     col:  req_col};

    // A forced start wins over a waiting upstream bundle, which stays parked.
    assign start_maint = (state_q == S_PASS) & init_calib_complete & maint_en
                       & (debt_q != 4'd0) & (~req_valid | (debt_q >= MAXP));
    assign req_ready   = (state_q == S_PASS) & init_calib_complete & ~start_maint;
    assign accept      = req_valid & req_ready;
    assign wdone       = (wcnt_q == WCW'(1));

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        zq_cnt_d  = zq_cnt_q;
        out_d     = nop_bundle();
        ref_issue = 1'b0;
        unique case (state_q)
            S_PASS: begin
                if (start_maint) begin
                    state_d    = S_PREA;
                    wcnt_d     = WCW'(TRP_CYC);
                    out_d.nop  = NOP_REST;
                    out_d.pall = SLOT0;
                end else if (accept) begin
                    out_d = req_b;
                end
            end
            S_PREA, S_WAIT_RP: begin
                if (wdone) begin
                    state_d    = S_REF;
                    wcnt_d     = WCW'(TRFC_CYC);
                    out_d.nop  = NOP_REST;
                    out_d.refr = SLOT0;
                    ref_issue  = 1'b1;
                end else begin
                    state_d = S_WAIT_RP;
                    wcnt_d  = wcnt_q - WCW'(1);
                end
            end
            S_REF, S_WAIT_RFC: begin
                if (wdone) begin
                    if (zq_cnt_q == ZCW'(ZQ_INTERVAL - 1)) begin
                        state_d   = S_ZQ;
                        wcnt_d    = WCW'(TZQCS_CYC);
                        zq_cnt_d  = '0;
                        out_d.nop = NOP_REST;
                        out_d.zq  = SLOT0;
                    end else begin
                        state_d  = S_PASS;
                        zq_cnt_d = zq_cnt_q + ZCW'(1);
                    end
                end else begin
                    state_d = S_WAIT_RFC;
                    wcnt_d  = wcnt_q - WCW'(1);
                end
            end
            S_ZQ, S_WAIT_ZQ: begin
                if (wdone) begin
                    state_d = S_PASS;
                end else begin
                    state_d = S_WAIT_ZQ;
                    wcnt_d  = wcnt_q - WCW'(1);
                end
            end
            default: state_d = S_PASS;
        endcase
    end

    always_comb begin
        debt_d = debt_q;
        ovf_d  = ovf_q;
        if (tick && !ref_issue) begin
            if (debt_q >= MAXP) begin
                ovf_d = 1'b1;
            end else begin
                debt_d = debt_q + 4'd1;
            end
        end else if (ref_issue && !tick && debt_q != 4'd0) begin
            debt_d = debt_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_PASS;
            wcnt_q   <= '0;
            zq_cnt_q <= '0;
            debt_q   <= '0;
            ovf_q    <= 1'b0;
            out_q    <= nop_bundle();
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            zq_cnt_q <= zq_cnt_d;
            debt_q   <= debt_d;
            ovf_q    <= ovf_d;
            out_q    <= out_d;
        end
    end

    assign ddr_write    = out_q.wr;
    assign ddr_read     = out_q.rd;
    assign ddr_pre      = out_q.pre;
    assign ddr_act      = out_q.act;
    assign ddr_ref      = out_q.refr;
    assign ddr_zq       = out_q.zq;
    assign ddr_nop      = out_q.nop;
    assign ddr_pall     = out_q.pall;
    assign ddr_bank     = out_q.bank;
    assign ddr_row      = out_q.row;
    assign ddr_col      = out_q.col;
    assign maint_busy   = (state_q != S_PASS);
    assign ref_debt     = debt_q;
    assign ref_overflow = ovf_q;

endmodule

// File: tb/tb_ddr3_maint_scheduler.sv
// Randomized scoreboard bench for ddr3_maint_scheduler against a
// timeline-based reference model of the maintenance rules.
module tb_ddr3_maint_scheduler;
    import ddr3_maint_scheduler_pkg::*;

    localparam int TREFI = 20;
    localparam int TRP   = 4;
    localparam int TRFC  = 10;
    localparam int TZQ   = 6;
    localparam int ZQI   = 2;
    localparam int MAXP  = 8;

    typedef struct packed {
        ddr_bundle_t out;
        logic        rdy;
        logic        busy;
        logic [3:0]  debt;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, calib, men, valid, ready;
    logic        busy, ovf;
    logic [3:0]  debt;
    ddr_bundle_t drv, got;
    logic [3:0]  o_wr, o_rd, o_pre, o_act, o_ref, o_zq, o_nop, o_pall;
    logic [4*BANK_WIDTH-1:0] o_bank;
    logic [4*ROW_WIDTH-1:0]  o_row;
    logic [4*COL_WIDTH-1:0]  o_col;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state: m_pos counts cycles since the PRE-ALL of the
    // current sequence, -1 when idle.
    int          m_debt, m_tcnt, m_pos, m_nref;
    bit          m_ovf, m_zq;
    ddr_bundle_t m_out;

    always #5 clk = ~clk;

    ddr3_maint_scheduler #(
        .TREFI_CYC(TREFI), .TRP_CYC(TRP), .TRFC_CYC(TRFC),
        .TZQCS_CYC(TZQ), .ZQ_INTERVAL(ZQI), .MAX_POSTPONE(MAXP)
    ) dut (
        .clk(clk), .rst(rst), .init_calib_complete(calib), .maint_en(men),
        .req_valid(valid), .req_ready(ready),
        .req_write(drv.wr), .req_read(drv.rd), .req_pre(drv.pre),
        .req_act(drv.act), .req_ref(drv.refr), .req_zq(drv.zq),
        .req_nop(drv.nop), .req_pall(drv.pall), .req_bank(drv.bank),
        .req_row(drv.row), .req_col(drv.col),
        .ddr_write(o_wr), .ddr_read(o_rd), .ddr_pre(o_pre), .ddr_act(o_act),
        .ddr_ref(o_ref), .ddr_zq(o_zq), .ddr_nop(o_nop), .ddr_pall(o_pall),
        .ddr_bank(o_bank), .ddr_row(o_row), .ddr_col(o_col),
        .maint_busy(busy), .ref_debt(debt), .ref_overflow(ovf)
    );

    assign got = {o_wr, o_rd, o_pre, o_act, o_ref, o_zq, o_nop, o_pall,
                  o_bank, o_row, o_col};

    function automatic ddr_bundle_t cmd_bundle(input int kind);
        ddr_bundle_t b;
        b = '0;
        if (kind == 0) begin
            b.nop = 4'hF;
        end else begin
            b.nop = 4'b1110;
            if (kind == 1) b.pall = 4'b0001;
            if (kind == 2) b.refr = 4'b0001;
            if (kind == 3) b.zq   = 4'b0001;
        end
        return b;
    endfunction

    function automatic bit model_start();
        return (m_pos < 0) && calib && men && (m_debt > 0)
            && (!valid || m_debt >= MAXP);
    endfunction

    task automatic chk(input string nm, input logic [159:0] a,
                       input logic [159:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s t=%0t got %h want %h", nm, $time, a, e);
        end
    endtask

    // Advance the model across the edge that just happened, using the
    // inputs that were presented during the cycle before it.
    task automatic model_step();
        bit tick, refi, start, rdy;
        tick  = calib && (m_tcnt == TREFI - 1);
        start = model_start();
        rdy   = (m_pos < 0) && calib && !start;
        refi  = 1'b0;
        if (rst) begin
            m_debt = 0; m_tcnt = 0; m_pos = -1; m_nref = 0;
            m_ovf = 1'b0; m_zq = 1'b0; m_out = cmd_bundle(0);
            return;
        end
        m_tcnt = (!calib || tick) ? 0 : m_tcnt + 1;
        m_out  = cmd_bundle(0);
        if (m_pos < 0) begin
            if (start) begin
                m_pos = 0;
                m_out = cmd_bundle(1);
            end else if (valid && rdy) begin
                m_out = drv;
            end
        end else begin
            m_pos++;
            if (m_pos == TRP) begin
                m_out = cmd_bundle(2);
                refi  = 1'b1;
                m_zq  = (m_nref % ZQI) == ZQI - 1;
                m_nref++;
            end else if (m_pos == TRP + TRFC) begin
                if (m_zq) m_out = cmd_bundle(3);
                else      m_pos = -1;
            end else if (m_zq && m_pos == TRP + TRFC + TZQ) begin
                m_pos = -1;
            end
        end
        if (tick && !refi) begin
            if (m_debt >= MAXP) m_ovf = 1'b1;
            else                m_debt++;
        end else if (refi && !tick && m_debt > 0) begin
            m_debt--;
        end
    endtask

    task automatic cyc(input bit r, input bit c, input bit m, input bit v);
        logic [159:0] rnd;
        exp_t e;
        @(posedge clk);
        #1;
        model_step();
        rnd   = {$urandom, $urandom, $urandom, $urandom, $urandom};
        drv   = rnd[$bits(ddr_bundle_t)-1:0];
        rst   = r;
        calib = c;
        men   = m;
        valid = v;
        e.out  = m_out;
        e.rdy  = (m_pos < 0) && calib && !model_start();
        e.busy = (m_pos >= 0);
        e.debt = 4'(m_debt);
        e.ovf  = m_ovf;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("bundle", 160'(got), 160'(e.out));
            chk("req_ready", 160'(ready), 160'(e.rdy));
            chk("maint_busy", 160'(busy), 160'(e.busy));
            chk("ref_debt", 160'(debt), 160'(e.debt));
            chk("ref_overflow", 160'(ovf), 160'(e.ovf));
        end
    end

    initial begin
        bit found;
        rst = 1'b1; calib = 1'b0; men = 1'b0; valid = 1'b0; drv = '0;
        m_debt = 0; m_tcnt = 0; m_pos = -1; m_nref = 0;
        m_ovf = 1'b0; m_zq = 1'b0; m_out = cmd_bundle(0);

        repeat (3) cyc(1, 0, 0, 0);
        repeat (120) cyc(0, 1, 1, 0);
        repeat (250) cyc(0, 1, 1, 1);
        repeat (200) cyc(0, 1, 1, 0);
        repeat (220) cyc(0, 1, 0, 1'($urandom));
        @(negedge clk);
        chk("ovf_sticky_set", 160'(ovf), 160'(1));
        chk("debt_saturated", 160'(debt), 160'(MAXP));
        repeat (300) cyc(0, 1, 1, ($urandom_range(0, 9) < 3));

        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            if (m_pos > TRP && m_pos < TRP + TRFC - 1) found = 1'b1;
            else cyc(0, 1, 1, 0);
        end
        if (!found) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rst_window t=%0t got none want WAIT_RFC", $time);
        end
        cyc(1, 0, 0, 0);
        repeat (5) cyc(0, 0, 1, 1);
        repeat (200) cyc(0, 1, 1, ($urandom_range(0, 9) < 4));
        repeat (2) cyc(0, 0, 0, 0);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain got %0d want 0 pending", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
